register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
// - Architectural register file with rename tags; sits downstream of the reorder buffer
//   and beside the instruction unit. Takes in-order commits (rd/value/rob id) from the ROB.
// - Records the ROB entry that will produce each register at issue time.
// - Supplies operand value or pending tag for rs1/rs2 to the instruction unit, RS and LSB.
// - Clears all rename state on a misprediction flush.
// PARAMETERS
// - ROB_INDEX_BIT  3   width of a ROB entry index/tag (ROB_CAP = 2**ROB_INDEX_BIT)
// - NUM_REGS       32  architectural registers; x0 hard-wired to zero
// PORTS
// - clk_in         in   1    clock, all state updates on rising edge
// - rst_in         in   1    reset, asynchronous, active-low
// - rdy_in         in   1    global ready; low = hold all state
// - clear_in       in   1    ROB misprediction flush
// - iss_req        in   1    instruction issued this cycle (rename request)
// - iss_rd         in   5    destination of issued instruction (0 = none)
// - iss_rob_id     in   ROB_INDEX_BIT  ROB tail slot allocated to it
// - cmt_rd         in   5    committing destination (0 = no write)
// - cmt_val        in   32   committed result
// - cmt_rob_id     in   ROB_INDEX_BIT  ROB entry committing
// - rs1_idx        in   5    read-port 1 register index
// - rs2_idx        in   5    read-port 2 register index
// - rs1_val        out  32   value of rs1 (valid when rs1_busy=0)
// - rs1_busy       out  1    rs1 awaits an in-flight ROB entry
// - rs1_tag        out  ROB_INDEX_BIT  producing ROB entry when rs1_busy=1, else 0
// - rs2_val/rs2_busy/rs2_tag  out  32/1/ROB_INDEX_BIT  same for rs2
// BEHAVIOUR
// - State per register r: val[r] (32b), busy[r] (1b), tag[r] (ROB_INDEX_BIT).
// - Reset (rst_in=0, async): all val=0, busy=0, tag=0; read outputs follow combinationally.
// - rdy_in=0 (reset high): no state change; read ports stay live.
// - Commit (rdy_in=1, cmt_rd!=0):
//   - val[cmt_rd] <= cmt_val unconditionally; commits are architectural, in order.
//   - If busy[cmt_rd] and tag[cmt_rd]==cmt_rob_id: busy <= 0, tag <= 0.
//   - Tag mismatch (register renamed again later): busy and tag unchanged.
// - Rename (rdy_in=1, clear_in=0, iss_req=1, iss_rd!=0):
//   - busy[iss_rd] <= 1; tag[iss_rd] <= iss_rob_id.
// - Same register renamed and committed in one cycle: value written, rename wins
//   (busy=1, tag=iss_rob_id).
// - Flush (clear_in=1, rdy_in=1):
//   - Every busy <= 0 and tag <= 0; iss_req ignored.
//   - A commit presented that cycle still writes val.
// - x0: never written, never busy; reads always give val=0, busy=0, tag=0.
// - Read ports: combinational, zero latency, with commit bypass.
//   - If rdy_in=1, cmt_rd==idx!=0, busy[idx]=1 and tag[idx]==cmt_rob_id:
//     output val=cmt_val, busy=0, tag=0.
//   - Otherwise output stored val/busy/tag.
//   - A same-cycle rename is NOT visible on read ports. The issuing instruction's own
//     sources see the pre-rename state, so rs1==rd is correct.
// - Registered state changes only on clock edges (rdy_in=1) or asynchronous reset.
//   Reset mid-operation discards all pending tags.
// TESTING
// - Reset: pulse rst_in=0 asynchronously between edges -> x1..x31 read val=0, busy=0 at once.
// - Rename then commit: issue rd=5 rob=3; next cycle read x5 -> busy=1, tag=3.
//   Commit rd=5 val=0xDEADBEEF rob=3 -> bypass busy=0, val=0xDEADBEEF; stored after edge.
// - Stale commit: rename x7 rob=1, then x7 rob=4; commit x7 rob=1 val=9
//   -> val[7]=9, busy=1, tag=4 remain.
// - Same-cycle collision: x2 busy tag=2; commit x2 rob=2 val=0x11 with issue rd=2 rob=6
//   -> after edge val=0x11, busy=1, tag=6.
// - Flush: rename x3,x4,x8; clear_in=1 with commit x9 val=0x55 (x9 tag matches)
//   -> all busy=0, val[9]=0x55, iss_req that cycle ignored.
// - x0 and rdy_in: commit rd=0 val=0x1234 and issue rd=0 -> x0 reads 0, not busy.
//   rdy_in=0 with commit x1 -> x1 unchanged.

Source files
------------

// File: rtl/register_file_if.sv
// register_file_if
//   Bundles the rename, commit and operand-read signals of the register file.
//   master : the issue/commit side (instruction unit + ROB), drives requests
//            and read indices, receives operand value/busy/tag.
//   slave  : the register file itself.
//   Ports (all logic):
//     iss_req, iss_rd[4:0], iss_rob_id    rename request from issue
//     cmt_rd[4:0], cmt_val[31:0], cmt_rob_id   in-order commit from ROB
//     rs1_idx/rs2_idx[4:0]                 read-port indices
//     rsN_val[31:0], rsN_busy, rsN_tag     read-port results
interface register_file_if #(
    parameter int ROB_INDEX_BIT = 3
);
    logic                     iss_req;
    logic [4:0]               iss_rd;
    logic [ROB_INDEX_BIT-1:0] iss_rob_id;

    logic [4:0]               cmt_rd;
    logic [31:0]              cmt_val;
    logic [ROB_INDEX_BIT-1:0] cmt_rob_id;

    logic [4:0]               rs1_idx;
    logic [4:0]               rs2_idx;
    logic [31:0]              rs1_val;
    logic                     rs1_busy;
    logic [ROB_INDEX_BIT-1:0] rs1_tag;
    logic [31:0]              rs2_val;
    logic                     rs2_busy;
    logic [ROB_INDEX_BIT-1:0] rs2_tag;

    modport master (
        output iss_req, iss_rd, iss_rob_id,
        output cmt_rd, cmt_val, cmt_rob_id,
        output rs1_idx, rs2_idx,
        input  rs1_val, rs1_busy, rs1_tag,
        input  rs2_val, rs2_busy, rs2_tag
    );

    modport slave (
        input  iss_req, iss_rd, iss_rob_id,
        input  cmt_rd, cmt_val, cmt_rob_id,
        input  rs1_idx, rs2_idx,
        output rs1_val, rs1_busy, rs1_tag,
        output rs2_val, rs2_busy, rs2_tag
    );
endinterface

// File: rtl/register_file.sv
// register_file
//   Architectural register file with per-register rename tags. Issue marks a
//   destination busy with the ROB entry that will produce it; in-order commits
//   write the value and clear busy only when the committing ROB id is still the
//   newest producer. A flush clears all rename state. x0 is constant zero.
//   Ports:
//     clk_in    clock, rising edge
//     rst_in    asynchronous active-low reset
//     rdy_in    global ready, low holds all state (read ports stay live)
//     clear_in  misprediction flush
//     bus       register_file_if.slave (rename, commit, two read ports)
module register_file #(
    parameter int ROB_INDEX_BIT = 3,
    parameter int NUM_REGS      = 32
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            clear_in,
    register_file_if.slave  bus
);

    logic [NUM_REGS-1:0][31:0]              val_q;
    logic [NUM_REGS-1:0]                    busy_q;
    logic [NUM_REGS-1:0][ROB_INDEX_BIT-1:0] tag_q;

    // Commit retires the newest producer of its destination.
    logic cmt_hit;
    assign cmt_hit = (bus.cmt_rd != '0) && busy_q[bus.cmt_rd] &&
                     (tag_q[bus.cmt_rd] == bus.cmt_rob_id);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            val_q  <= '0;
            busy_q <= '0;
            tag_q  <= '0;
        end else if (rdy_in) begin
            if (bus.cmt_rd != '0) begin
                val_q[bus.cmt_rd] <= bus.cmt_val;
                if (cmt_hit) begin
                    busy_q[bus.cmt_rd] <= 1'b0;
                    tag_q[bus.cmt_rd]  <= '0;
                end
            end
            // Placed after the commit so a same-register rename overrides the
            // commit's busy clear (last non-blocking assignment wins).
            if (clear_in) begin
                busy_q <= '0;
                tag_q  <= '0;
            end else if (bus.iss_req && bus.iss_rd != '0) begin
                busy_q[bus.iss_rd] <= 1'b1;
                tag_q[bus.iss_rd]  <= bus.iss_rob_id;
            end
        end
    end

    // Read ports: stored state with commit bypass; a same-cycle rename is
    // deliberately invisible so the issuing instruction sees its old sources.
    always_comb begin
        bus.rs1_val  = val_q[bus.rs1_idx];
        bus.rs1_busy = busy_q[bus.rs1_idx];
        bus.rs1_tag  = tag_q[bus.rs1_idx];
        if (rdy_in && cmt_hit && bus.cmt_rd == bus.rs1_idx) begin
            bus.rs1_val  = bus.cmt_val;
            bus.rs1_busy = 1'b0;
            bus.rs1_tag  = '0;
        end
    end

    always_comb begin
        bus.rs2_val  = val_q[bus.rs2_idx];
        bus.rs2_busy = busy_q[bus.rs2_idx];
        bus.rs2_tag  = tag_q[bus.rs2_idx];
        if (rdy_in && cmt_hit && bus.cmt_rd == bus.rs2_idx) begin
            bus.rs2_val  = bus.cmt_val;
            bus.rs2_busy = 1'b0;
            bus.rs2_tag  = '0;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file
//   Directed test of register_file: reset, rename/commit with bypass, stale
//   commit, same-cycle rename+commit, flush, x0 and rdy_in hold.
module tb_register_file;

    localparam int RIB = 3;

    logic clk_in;
    logic rst_in;
    logic rdy_in;
    logic clear_in;

    int checks;
    int errors;

    register_file_if #(.ROB_INDEX_BIT(RIB)) rf_bus ();

    register_file #(.ROB_INDEX_BIT(RIB), .NUM_REGS(32)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .clear_in (clear_in),
        .bus      (rf_bus)
    );

    initial clk_in = 1'b0;
    always #50 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd1(input string tag, input logic [31:0] v, input logic b, input logic [RIB-1:0] t);
        chk({tag, "_val"},  rf_bus.rs1_val,  v);
        chk({tag, "_busy"}, {31'b0, rf_bus.rs1_busy}, {31'b0, b});
        chk({tag, "_tag"},  {29'b0, rf_bus.rs1_tag},  {29'b0, t});
    endtask

    task automatic rd2(input string tag, input logic [31:0] v, input logic b, input logic [RIB-1:0] t);
        chk({tag, "_val"},  rf_bus.rs2_val,  v);
        chk({tag, "_busy"}, {31'b0, rf_bus.rs2_busy}, {31'b0, b});
        chk({tag, "_tag"},  {29'b0, rf_bus.rs2_tag},  {29'b0, t});
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rf_bus.iss_req    = 1'b0;
        rf_bus.iss_rd     = '0;
        rf_bus.iss_rob_id = '0;
        rf_bus.cmt_rd     = '0;
        rf_bus.cmt_val    = '0;
        rf_bus.cmt_rob_id = '0;
        clear_in          = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [RIB-1:0] rob);
        rf_bus.iss_req    = 1'b1;
        rf_bus.iss_rd     = rd;
        rf_bus.iss_rob_id = rob;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [31:0] v, input logic [RIB-1:0] rob);
        rf_bus.cmt_rd     = rd;
        rf_bus.cmt_val    = v;
        rf_bus.cmt_rob_id = rob;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_in = 1'b0;
        rdy_in = 1'b1;
        idle();
        rf_bus.rs1_idx = 5'd1;
        rf_bus.rs2_idx = 5'd31;
        tick();
        tick();
        rd1("rst_x1", 32'h0, 1'b0, 3'd0);
        rd2("rst_x31", 32'h0, 1'b0, 3'd0);
        @(negedge clk_in);
        rst_in = 1'b1;

        // Populate some state, then pulse reset between edges.
        tick();
        commit(5'd1, 32'h0000_00A5, 3'd0);
        issue(5'd5, 3'd3);
        tick();
        idle();
        rf_bus.rs2_idx = 5'd5;
        #1;
        rd1("pre_x1", 32'h0000_00A5, 1'b0, 3'd0);
        rd2("pre_x5", 32'h0, 1'b1, 3'd3);
        rst_in = 1'b0;
        #1;
        for (int i = 1; i < 32; i++) begin
            rf_bus.rs1_idx = 5'(i);
            #1;
            chk("async_rst_val",  rf_bus.rs1_val, 32'h0);
            chk("async_rst_busy", {31'b0, rf_bus.rs1_busy}, 32'h0);
        end
        rst_in = 1'b1;

        // Rename then commit with bypass.
        tick();
        issue(5'd5, 3'd3);
        rf_bus.rs1_idx = 5'd5;
        #1;
        rd1("ren_same_cycle", 32'h0, 1'b0, 3'd0);
        tick();
        idle();
        #1;
        rd1("ren_x5", 32'h0, 1'b1, 3'd3);
        commit(5'd5, 32'hDEAD_BEEF, 3'd3);
        #1;
        rd1("byp_x5", 32'hDEAD_BEEF, 1'b0, 3'd0);
        tick();
        idle();
        #1;
        rd1("cmt_x5", 32'hDEAD_BEEF, 1'b0, 3'd0);

        // Stale commit leaves the newer rename in place.
        issue(5'd7, 3'd1);
        tick();
        issue(5'd7, 3'd4);
        tick();
        idle();
        commit(5'd7, 32'd9, 3'd1);
        rf_bus.rs1_idx = 5'd7;
        #1;
        rd1("stale_nobyp", 32'h0, 1'b1, 3'd4);
        tick();
        idle();
        #1;
        rd1("stale_x7", 32'd9, 1'b1, 3'd4);

        // Same-cycle commit and rename of one register.
        issue(5'd2, 3'd2);
        tick();
        idle();
        commit(5'd2, 32'h11, 3'd2);
        issue(5'd2, 3'd6);
        rf_bus.rs1_idx = 5'd2;
        #1;
        rd1("coll_byp", 32'h11, 1'b0, 3'd0);
        tick();
        idle();
        #1;
        rd1("coll_x2", 32'h11, 1'b1, 3'd6);

        // Flush with a concurrent commit and an ignored issue.
        issue(5'd3, 3'd5);
        tick();
        issue(5'd4, 3'd6);
        tick();
        issue(5'd8, 3'd7);
        tick();
        issue(5'd9, 3'd1);
        tick();
        idle();
        rf_bus.rs1_idx = 5'd8;
        rf_bus.rs2_idx = 5'd9;
        #1;
        rd1("pre_fl_x8", 32'h0, 1'b1, 3'd7);
        rd2("pre_fl_x9", 32'h0, 1'b1, 3'd1);
        clear_in = 1'b1;
        commit(5'd9, 32'h55, 3'd1);
        issue(5'd10, 3'd2);
        tick();
        idle();
        #1;
        rd1("fl_x8", 32'h0, 1'b0, 3'd0);
        rd2("fl_x9", 32'h55, 1'b0, 3'd0);
        rf_bus.rs1_idx = 5'd3;
        rf_bus.rs2_idx = 5'd4;
        #1;
        rd1("fl_x3", 32'h0, 1'b0, 3'd0);
        rd2("fl_x4", 32'h0, 1'b0, 3'd0);
        rf_bus.rs1_idx = 5'd10;
        rf_bus.rs2_idx = 5'd2;
        #1;
        rd1("fl_x10_ign", 32'h0, 1'b0, 3'd0);
        rd2("fl_x2", 32'h11, 1'b0, 3'd0);
        rf_bus.rs1_idx = 5'd7;
        #1;
        rd1("fl_x7", 32'd9, 1'b0, 3'd0);

        // x0 is never written nor renamed.
        commit(5'd0, 32'h1234, 3'd0);
        issue(5'd0, 3'd3);
        rf_bus.rs1_idx = 5'd0;
        #1;
        rd1("x0_byp", 32'h0, 1'b0, 3'd0);
        tick();
        idle();
        #1;
        rd1("x0_after", 32'h0, 1'b0, 3'd0);

        // rdy_in low holds state and suppresses the bypass.
        issue(5'd1, 3'd2);
        tick();
        idle();
        rdy_in = 1'b0;
        commit(5'd1, 32'hCAFE, 3'd2);
        issue(5'd1, 3'd5);
        rf_bus.rs1_idx = 5'd1;
        #1;
        rd1("rdy0_nobyp", 32'h0, 1'b1, 3'd2);
        tick();
        #1;
        rd1("rdy0_hold", 32'h0, 1'b1, 3'd2);
        rf_bus.iss_req = 1'b0;
        rdy_in = 1'b1;
        #1;
        rd1("rdy1_byp", 32'hCAFE, 1'b0, 3'd0);
        tick();
        idle();
        #1;
        rd1("rdy1_x1", 32'hCAFE, 1'b0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
